seg_scan_mux: RTL

Time-multiplexed scan driver for the 4-digit common-anode seven-segment display. It takes four 5-bit digit codes and selects one per scan slot, presenting it on `digit` to the downstream segment decoder. It drives the active-low anodes with a dead-time guard against ghosting and applies optional per-digit blinking. It sits between the game/score logic and the segment-code decoder.

---
 rtl/seg_pkg.sv | 32 +++
 rtl/tick_divider.sv | 43 ++++
 rtl/seg_scan_mux.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared definitions for the seven-segment scan path.
//   BLANK_CODE      - digit code that the decoder renders as all segments off
//   CODE_*          - character codes shared with the upstream producers
//   scan_state_e    - scan slot phase (BLANK dead-time, SHOW digit lit)
//   NUM_DIGITS      - number of multiplexed digits
//   anode_for()     - active-low one-cold anode pattern for a digit index
package seg_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int IDX_W      = $clog2(NUM_DIGITS);

  localparam logic [4:0] BLANK_CODE = 5'b11111;

  localparam logic [4:0] CODE_L = 5'h0A;
  localparam logic [4:0] CODE_R = 5'h0B;
  localparam logic [4:0] CODE_I = 5'h0C;
  localparam logic [4:0] CODE_N = 5'h0D;
  localparam logic [4:0] CODE_T = 5'h0E;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_e;

  function automatic logic [NUM_DIGITS-1:0] anode_for(input logic [IDX_W-1:0] idx);
    logic [NUM_DIGITS-1:0] onehot;
    onehot = '0;
    onehot[idx] = 1'b1;
    return ~onehot;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// tick_divider: free-running modulo-DIV counter with a one-cycle wrap pulse.
//   clk   - clock
//   reset - synchronous active-high reset (counter to 0)
//   en    - count enable; the counter holds its value while low
//   tick  - high in the cycle the counter sits at DIV-1 with en high,
//           i.e. the edge that closes this cycle wraps the counter
module tick_divider #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (en) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed scan driver for a 4-digit common-anode
// seven-segment display.
//   clk, reset   - clock, synchronous active-high reset
//   enable       - 1 scans the display, 0 keeps it dark and parks the scan
//   d0..d3       - 5-bit digit codes (d0 is the rightmost digit, an[0])
//   dp_in        - per-digit decimal point request, 1 = lit
//   blink_en     - per-digit blink enable
//   an           - active-low anode enables (at most one low)
//   digit        - code forwarded to the segment decoder
//   dp           - active-low decimal point
// Every slot opens with BLANK_CYCLES of all-anodes-off dead time to stop
// ghosting between digits. Inputs are sampled once per frame so a digit
// never changes part-way through a scan.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int BLINK_DIV    = 25000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [4:0]            d0,
  input  logic [4:0]            d1,
  input  logic [4:0]            d2,
  input  logic [4:0]            d3,
  input  logic [NUM_DIGITS-1:0] dp_in,
  input  logic [NUM_DIGITS-1:0] blink_en,
  output logic [NUM_DIGITS-1:0] an,
  output logic [4:0]            digit,
  output logic                  dp
);

  localparam int SW = $clog2(REFRESH_DIV);
  localparam logic [SW-1:0] SLOT_LAST = SW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] BLANK_END = SW'(BLANK_CYCLES);

  logic [NUM_DIGITS-1:0][4:0] d_in;
  assign d_in = {d3, d2, d1, d0};

  // Scan state
  logic [SW-1:0]    slot_cnt_q, slot_cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  scan_state_e      state_q, state_d;
  logic             en_prev_q, en_prev_d;
  logic             blink_ph_q, blink_ph_d;

  // Frame snapshot
  logic [NUM_DIGITS-1:0][4:0] snap_d_q, snap_d_d;
  logic [NUM_DIGITS-1:0]      snap_dp_q, snap_dp_d;
  logic [NUM_DIGITS-1:0]      snap_blink_q, snap_blink_d;

  // Registered outputs
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [4:0]            digit_q, digit_d;
  logic                  dp_q, dp_d;

  logic                  blink_tick;
  logic                  slot_wrap;
  logic                  snap_load;
  logic [NUM_DIGITS-1:0] an_show;

  tick_divider #(
    .DIV (BLINK_DIV)
  ) u_blink_div (
    .clk   (clk),
    .reset (reset),
    .en    (enable),
    .tick  (blink_tick)
  );

  // Anode pattern for the current digit; decoded per bit.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_an
    assign an_show[gi] = (idx_q != IDX_W'(gi));
  end

  always_comb begin
    slot_cnt_d   = slot_cnt_q;
    idx_d        = idx_q;
    en_prev_d    = enable;
    snap_d_d     = snap_d_q;
    snap_dp_d    = snap_dp_q;
    snap_blink_d = snap_blink_q;
    an_d         = '1;
    digit_d      = BLANK_CODE;
    dp_d         = 1'b1;
    slot_wrap    = (slot_cnt_q == SLOT_LAST);
    snap_load    = 1'b0;
    // The blink counter only advances while enabled, so toggling here
    // needs no extra qualification.
    blink_ph_d   = blink_ph_q ^ blink_tick;

    if (!enable) begin
      // Parked: the next enable starts a fresh frame at slot 0.
      slot_cnt_d = '0;
      idx_d      = '0;
    end else begin
      if (slot_wrap) begin
        slot_cnt_d = '0;
        idx_d      = idx_q + 1'b1;
      end else begin
        slot_cnt_d = slot_cnt_q + 1'b1;
      end

      // Sample inputs at the frame boundary, and on the first enabled
      // cycle so a restarted scan never shows stale codes.
      snap_load = (!en_prev_q) || (slot_wrap && (idx_q == IDX_W'(NUM_DIGITS - 1)));
      if (snap_load) begin
        snap_d_d     = d_in;
        snap_dp_d    = dp_in;
        snap_blink_d = blink_en;
      end

      if ((state_q == SHOW) && !(blink_ph_q && snap_blink_q[idx_q])) begin
        an_d    = an_show;
        digit_d = snap_d_q[idx_q];
        dp_d    = ~snap_dp_q[idx_q];
      end
    end

    // Phase follows the counter value it is registered alongside.
    state_d = (slot_cnt_d < BLANK_END) ? BLANK : SHOW;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt_q   <= '0;
      idx_q        <= '0;
      state_q      <= BLANK;
      en_prev_q    <= 1'b0;
      blink_ph_q   <= 1'b0;
      snap_d_q     <= {NUM_DIGITS{BLANK_CODE}};
      snap_dp_q    <= '0;
      snap_blink_q <= '0;
      an_q         <= '1;
      digit_q      <= BLANK_CODE;
      dp_q         <= 1'b1;
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      idx_q        <= idx_d;
      state_q      <= state_d;
      en_prev_q    <= en_prev_d;
      blink_ph_q   <= blink_ph_d;
      snap_d_q     <= snap_d_d;
      snap_dp_q    <= snap_dp_d;
      snap_blink_q <= snap_blink_d;
      an_q         <= an_d;
      digit_q      <= digit_d;
      dp_q         <= dp_d;
    end
  end

  assign an    = an_q;
  assign digit = digit_q;
  assign dp    = dp_q;

endmodule
